dvp_rx: RTL and testbench

- Receiver for the parallel camera-style bus the FPGA drives toward the CPU: pixel clock, VSYNC, HSYNC and 14-bit data.
- Oversamples the bus on one fast system clock and recovers framed pixels into a small FIFO.
- Presents the pixels as a valid/ready stream tagged with start-of-frame and end-of-line.
- Serves as the loopback checker for the video output path and as the capture front-end on test fixtures.

---
 rtl/video_pkg.sv | 17 +
 rtl/dvp_rx_if.sv | 23 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/dvp_rx.sv | 215 +++++++++++++++++++++
 tb/tb_dvp_rx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video-path types: FSM encoding and FIFO entry layout.
// FIFO entry is {data, sof, eol}, so eol is bit 0 and data starts at bit 2.
package video_pkg;

  localparam int DVP_DW = 14;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    ARMED     = 2'd1,
    FRAME     = 2'd2
  } dvp_state_t;

  localparam int EOL_BIT = 0;
  localparam int SOF_BIT = 1;
  localparam int DAT_LSB = 2;

endpackage

// File: rtl/dvp_rx_if.sv
// Pixel stream with valid/ready handshake and frame/line tags.
// Signals: data, sof (first pixel of frame), eol (last of line), valid, ready.
interface dvp_rx_if #(
  parameter int DW = 14
) ();

  logic [DW-1:0] data;
  logic          sof;
  logic          eol;
  logic          valid;
  logic          ready;

  modport master (
    output data, sof, eol, valid,
    input  ready
  );

  modport slave (
    input  data, sof, eol, valid,
    output ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output.
// Ports: push/din write side; rd_en/dout/valid read side; full status.
module sync_fifo #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   mcnt;
  logic          pop;
  logic          wr;
  logic          load;

  // Output register counts toward capacity, so the
  // total number of stored entries never exceeds DEPTH.
  assign full = (mcnt + {{AW{1'b0}}, valid}) == DEPTH_C;
  assign pop  = rd_en && valid;
  assign wr   = push && (!full || pop);
  assign load = (mcnt != '0) && (!valid || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      mcnt  <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (load) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      case ({wr, load})
        2'b10:   mcnt <= mcnt + 1'b1;
        2'b01:   mcnt <= mcnt - 1'b1;
        default: mcnt <= mcnt;
      endcase
      if (load)     valid <= 1'b1;
      else if (pop) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dvp_rx.sv
// Parallel camera-bus receiver: oversamples pclk/vsync/hsync/data on clk,
// frames pixels into a FIFO and streams them out tagged with sof/eol.
// Ports: clk, rst, enable, clr_err, vid_* bus, m (stream master),
// frame_done, line_len, line_cnt, busy, ovf_err, len_err.
module dvp_rx
  import video_pkg::*;
#(
  parameter int DW      = DVP_DW,
  parameter int FIFO_AW = 4,
  parameter int XW      = 13,
  parameter int YW      = 12,
  parameter bit VS_POL  = 1'b1,
  parameter bit HS_POL  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clr_err,
  input  logic          vid_pclk,
  input  logic          vid_vsync,
  input  logic          vid_hsync,
  input  logic [DW-1:0] vid_d,
  dvp_rx_if.master      m,
  output logic          frame_done,
  output logic [XW-1:0] line_len,
  output logic [YW-1:0] line_cnt,
  output logic          busy,
  output logic          ovf_err,
  output logic          len_err
);

  // [0] sync stage 1, [1] sync stage 2, [2] edge register
  logic [2:0]    pclk_sr;
  logic [2:0]    vs_sr;
  logic [2:0]    hs_sr;
  logic [DW-1:0] d_s1;
  logic [DW-1:0] d_s2;

  // vsync syncs reset to the active level so WAIT_IDLE only leaves
  // once a real inactive vsync has propagated through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_sr <= '0;
      vs_sr   <= {3{VS_POL}};
      hs_sr   <= {3{~HS_POL}};
      d_s1    <= '0;
      d_s2    <= '0;
    end else begin
      pclk_sr <= {pclk_sr[1:0], vid_pclk};
      vs_sr   <= {vs_sr[1:0], vid_vsync};
      hs_sr   <= {hs_sr[1:0], vid_hsync};
      d_s1    <= vid_d;
      d_s2    <= d_s1;
    end
  end

  logic pclk_rise;
  logic vs_act;
  logic vs_act_d;
  logic hs_act;
  logic hs_act_d;
  logic vs_rise;
  logic vs_fall;
  logic hs_fall;

  assign pclk_rise = pclk_sr[1] && !pclk_sr[2];
  assign vs_act    = (vs_sr[1] == VS_POL);
  assign vs_act_d  = (vs_sr[2] == VS_POL);
  assign hs_act    = (hs_sr[1] == HS_POL);
  assign hs_act_d  = (hs_sr[2] == HS_POL);
  assign vs_rise   = vs_act && !vs_act_d;
  assign vs_fall   = !vs_act && vs_act_d;
  assign hs_fall   = !hs_act && hs_act_d;

  dvp_state_t state;
  dvp_state_t state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    unique case (state)
      WAIT_IDLE: if (!vs_act) state_n = ARMED;
      ARMED:     if (vs_rise && enable) state_n = FRAME;
      FRAME: begin
        busy = 1'b1;
        if (vs_fall) state_n = ARMED;
      end
      default:   state_n = WAIT_IDLE;
    endcase
  end

  logic in_frame;
  logic frame_start;
  logic frame_end;
  logic line_end;
  logic pix_take;

  assign in_frame    = (state == FRAME);
  assign frame_start = (state == ARMED) && vs_rise && enable;
  assign frame_end   = in_frame && vs_fall;
  assign line_end    = in_frame && hs_fall;
  assign pix_take    = in_frame && pclk_rise && hs_act && !vs_fall;

  logic          hold_v;
  logic [DW-1:0] hold_d;
  logic          sof_pend;
  logic          push;
  logic          push_eol;

  // Line end wins over a coinciding pixel: the held pixel goes out
  // with eol and the new pixel becomes the next held one.
  always_comb begin
    push     = 1'b0;
    push_eol = 1'b0;
    if (line_end) begin
      push     = hold_v;
      push_eol = 1'b1;
    end else if (frame_end) begin
      push     = hold_v;
      push_eol = hs_act;
    end else if (pix_take) begin
      push     = hold_v;
    end
  end

  logic [DW+1:0] fifo_din;
  logic [DW+1:0] fifo_q;
  logic          fifo_valid;
  logic          fifo_full;
  logic          pop;
  logic          ovf_ev;
  logic          len_ev;

  always_comb begin
    fifo_din = '0;
    fifo_din[DAT_LSB +: DW] = hold_d;
    fifo_din[SOF_BIT]       = sof_pend;
    fifo_din[EOL_BIT]       = push_eol;
  end

  sync_fifo #(
    .W  (DW + 2),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .rd_en (m.ready),
    .dout  (fifo_q),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign m.data  = fifo_q[DAT_LSB +: DW];
  assign m.sof   = fifo_q[SOF_BIT];
  assign m.eol   = fifo_q[EOL_BIT];
  assign m.valid = fifo_valid;

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [YW-1:0] y_fin;

  assign pop    = fifo_valid && m.ready;
  assign ovf_ev = push && fifo_full && !pop;
  assign len_ev = line_end && (y_cnt != '0) && (x_cnt != line_len);
  assign y_fin  = (line_end && y_cnt != '1) ? y_cnt + 1'b1 : y_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v     <= 1'b0;
      hold_d     <= '0;
      sof_pend   <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      line_len   <= '0;
      line_cnt   <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_start) begin
        hold_v   <= 1'b0;
        sof_pend <= 1'b1;
        x_cnt    <= '0;
        y_cnt    <= '0;
      end else if (in_frame) begin
        if (push) sof_pend <= 1'b0;
        if (line_end || vs_fall) hold_v <= 1'b0;
        if (pix_take) begin
          hold_v <= 1'b1;
          hold_d <= d_s2;
        end
        if (line_end)
          x_cnt <= pix_take ? XW'(1) : '0;
        else if (pix_take && x_cnt != '1)
          x_cnt <= x_cnt + 1'b1;
        y_cnt <= y_fin;
        if (line_end && y_cnt == '0) line_len <= x_cnt;
        if (frame_end) line_cnt <= y_fin;
      end
      if (ovf_ev)       ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
      if (len_ev)       len_err <= 1'b1;
      else if (clr_err) len_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvp_rx.sv
// Directed bench for dvp_rx: frames, mid-frame reset, backpressure,
// ragged lines, enable gating and inverted sync polarity.
`timescale 1ns/1ps
module tb_dvp_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clr_err;
  logic        vid_pclk;
  logic        vid_vsync;
  logic        vid_hsync;
  logic [13:0] vid_d;

  dvp_rx_if #(.DW(14)) s1 ();
  dvp_rx_if #(.DW(14)) s2 ();

  logic        fd1, fd2;
  logic [12:0] ll1, ll2;
  logic [11:0] lc1, lc2;
  logic        busy1, busy2;
  logic        ovf1, ovf2;
  logic        le1, le2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign s2.ready = 1'b1;

  dvp_rx #(.FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .vid_pclk(vid_pclk), .vid_vsync(vid_vsync),
    .vid_hsync(vid_hsync), .vid_d(vid_d), .m(s1),
    .frame_done(fd1), .line_len(ll1), .line_cnt(lc1),
    .busy(busy1), .ovf_err(ovf1), .len_err(le1)
  );

  dvp_rx #(.FIFO_AW(2), .VS_POL(1'b0), .HS_POL(1'b0)) dut_inv (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .vid_pclk(vid_pclk), .vid_vsync(~vid_vsync),
    .vid_hsync(~vid_hsync), .vid_d(vid_d), .m(s2),
    .frame_done(fd2), .line_len(ll2), .line_cnt(lc2),
    .busy(busy2), .ovf_err(ovf2), .len_err(le2)
  );

  logic [15:0] b1 [0:511];
  logic [15:0] b2 [0:511];
  int n1 = 0, n2 = 0, fd_cnt = 0, busy_cnt = 0;
  int rd1 = 0, rd2 = 0, fd0 = 0, bz0 = 0;

  always @(negedge clk) begin
    if (s1.valid && s1.ready && n1 < 512) begin
      b1[n1] = {s1.sof, s1.eol, s1.data};
      n1++;
    end
    if (s2.valid && s2.ready && n2 < 512) begin
      b2[n2] = {s2.sof, s2.eol, s2.data};
      n2++;
    end
    if (fd1) fd_cnt++;
    if (busy1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  task automatic tick(input logic vs, input logic hs,
                      input logic [13:0] d);
    vid_vsync = vs;
    vid_hsync = hs;
    vid_d     = d;
    #25 vid_pclk = 1'b1;
    #25 vid_pclk = 1'b0;
  endtask

  task automatic do_evt(input int k);
    case (k)
      1: begin
        rst = 1'b1;
        #17 rst = 1'b0;
        rd1 = n1;
        fd0 = fd_cnt;
      end
      2: enable = 1'b1;
      3: enable = 1'b0;
      default: ;
    endcase
  endtask

  task automatic send_frame(input int nl, input int len, input int last,
                            input int ey, input int ex, input int ek);
    int l;
    tick(1'b0, 1'b0, 14'h0);
    tick(1'b0, 1'b0, 14'h0);
    tick(1'b1, 1'b0, 14'h0);
    tick(1'b1, 1'b0, 14'h0);
    for (int y = 0; y < nl; y++) begin
      l = (y == nl - 1) ? last : len;
      for (int x = 0; x < l; x++) begin
        if (y == ey && x == ex) do_evt(ek);
        tick(1'b1, 1'b1, 14'(y * 16 + x));
      end
      tick(1'b1, 1'b0, 14'h0);
      tick(1'b1, 1'b0, 14'h0);
    end
    tick(1'b0, 1'b0, 14'h0);
    tick(1'b0, 1'b0, 14'h0);
    tick(1'b0, 1'b0, 14'h0);
  endtask

  task automatic chk_frame(input int which, input int nl, input int len,
                           input int last, input string tag);
    int l;
    logic [16:0] e, o;
    for (int y = 0; y < nl; y++) begin
      l = (y == nl - 1) ? last : len;
      for (int x = 0; x < l; x++) begin
        e = {1'b1, (y == 0 && x == 0), (x == l - 1), 14'(y * 16 + x)};
        o = '0;
        if (which == 1 && rd1 < n1) begin
          o = {1'b1, b1[rd1]};
          rd1++;
        end
        if (which == 2 && rd2 < n2) begin
          o = {1'b1, b2[rd2]};
          rd2++;
        end
        chk(tag, 32'(o), 32'(e));
      end
    end
    if (which == 1) chk({tag, " extra"}, n1 - rd1, 0);
    else            chk({tag, " extra"}, n2 - rd2, 0);
  endtask

  initial begin
    logic [16:0] e, o;
    rst       = 1'b1;
    enable    = 1'b1;
    clr_err   = 1'b0;
    vid_pclk  = 1'b0;
    vid_vsync = 1'b0;
    vid_hsync = 1'b0;
    vid_d     = '0;
    s1.ready  = 1'b1;

    #12;
    chk("rst valid", s1.valid, 0);
    chk("rst frame_done", fd1, 0);
    chk("rst line_len", ll1, 0);
    chk("rst line_cnt", lc1, 0);
    chk("rst busy", busy1, 0);
    chk("rst ovf_err", ovf1, 0);
    chk("rst len_err", le1, 0);
    rst = 1'b0;
    #10;
    chk("idle busy", busy1, 0);

    // basic frame, also watched on the inverted-polarity instance
    fd0 = fd_cnt;
    send_frame(4, 8, 8, -1, -1, 0);
    settle(30);
    chk_frame(1, 4, 8, 8, "s1 beat");
    chk("s1 frame_done", fd_cnt - fd0, 1);
    chk("s1 line_cnt", lc1, 4);
    chk("s1 line_len", ll1, 8);
    chk("s1 ovf_err", ovf1, 0);
    chk("s1 len_err", le1, 0);
    chk_frame(2, 4, 8, 8, "pol beat");
    chk("pol line_cnt", lc2, 4);
    chk("pol line_len", ll2, 8);

    // reset in the middle of line 2
    send_frame(4, 8, 8, 2, 3, 1);
    settle(30);
    chk("rst partial beats", n1 - rd1, 0);
    chk("rst partial done", fd_cnt - fd0, 0);
    chk("rst partial line_cnt", lc1, 0);
    chk("rst partial busy", busy1, 0);
    fd0 = fd_cnt;
    send_frame(4, 8, 8, -1, -1, 0);
    settle(30);
    chk_frame(1, 4, 8, 8, "s2 beat");
    chk("s2 frame_done", fd_cnt - fd0, 1);
    chk("s2 line_cnt", lc1, 4);

    // backpressure on a 16-pixel line, 4-entry FIFO
    s1.ready = 1'b0;
    fd0 = fd_cnt;
    send_frame(1, 16, 16, -1, -1, 0);
    settle(30);
    chk("s3 ovf_err", ovf1, 1);
    chk("s3 valid", s1.valid, 1);
    chk("s3 frame_done", fd_cnt - fd0, 1);
    chk("s3 line_len", ll1, 16);
    chk("s3 line_cnt", lc1, 1);
    chk("s3 no pop", n1 - rd1, 0);
    clr_pulse();
    settle(2);
    chk("s3 ovf clr", ovf1, 0);
    s1.ready = 1'b1;
    settle(20);
    for (int x = 0; x < 4; x++) begin
      e = {1'b1, (x == 0), 1'b0, 14'(x)};
      o = '0;
      if (rd1 < n1) begin
        o = {1'b1, b1[rd1]};
        rd1++;
      end
      chk("s3 drain", 32'(o), 32'(e));
    end
    chk("s3 drain extra", n1 - rd1, 0);
    chk("s3 empty", s1.valid, 0);

    // ragged lines 8, 8, 7
    fd0 = fd_cnt;
    send_frame(3, 8, 7, -1, -1, 0);
    settle(30);
    chk_frame(1, 3, 8, 7, "s4 beat");
    chk("s4 len_err", le1, 1);
    chk("s4 line_len", ll1, 8);
    chk("s4 line_cnt", lc1, 3);
    chk("s4 frame_done", fd_cnt - fd0, 1);
    clr_pulse();
    settle(2);
    chk("s4 len clr", le1, 0);

    // enable low at frame start, raised mid-frame
    enable = 1'b0;
    fd0 = fd_cnt;
    bz0 = busy_cnt;
    send_frame(2, 4, 4, 1, 0, 2);
    settle(30);
    chk("s5 gated busy", busy_cnt - bz0, 0);
    chk("s5 gated beats", n1 - rd1, 0);
    chk("s5 gated done", fd_cnt - fd0, 0);
    // enable high at frame start, dropped mid-frame
    fd0 = fd_cnt;
    bz0 = busy_cnt;
    send_frame(2, 4, 4, 1, 0, 3);
    settle(30);
    chk_frame(1, 2, 4, 4, "s5 beat");
    chk("s5 frame_done", fd_cnt - fd0, 1);
    chk("s5 busy seen", (busy_cnt - bz0) > 0, 1);
    chk("s5 line_cnt", lc1, 2);
    chk("s5 line_len", ll1, 4);
    enable = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
